// File: rtl/mfe_pkg.sv
// ============================================================================
// Module      : mfe_pkg
// Description : Shared constants and types for the 3x3 window generator.
//               Optional macro MFE_WIN_REPLICATE_EN (used by mfe_line_store)
//               selects edge replication instead of zero padding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mfe_pkg;

   // Default frame geometry and pixel depth
   localparam int DEF_IMG_W  = 128;
   localparam int DEF_IMG_H  = 128;
   localparam int DEF_PIX_W  = 8;

   // Window shape: taps 0..8 in raster order, tap 4 is the centre pixel
   localparam int NUM_TAPS   = 9;
   localparam int CENTRE_TAP = 4;

   // Frame sequencing states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // One window at the default pixel depth
   typedef logic [DEF_PIX_W-1:0] win_t [NUM_TAPS];

endpackage : mfe_pkg

`default_nettype wire

// File: rtl/mfe_line_store.sv
// ============================================================================
// Module      : mfe_line_store
// Description : 3*IMG_W-entry circular pixel store. One write port, nine
//               combinational read taps around a centre position. Taps that
//               fall outside the image read 0, or the nearest in-image pixel
//               when MFE_WIN_REPLICATE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mfe_line_store
   import mfe_pkg::*;
#(
   parameter int IMG_W  = DEF_IMG_W,
   parameter int IMG_H  = DEF_IMG_H,
   parameter int PIX_W  = DEF_PIX_W,
   parameter int ADDR_W = $clog2(3*IMG_W),
   parameter int ROW_W  = $clog2(IMG_H),
   parameter int COL_W  = $clog2(IMG_W)
)(
   input  logic                      clk,
   input  logic                      i_wr_en,
   input  logic [ADDR_W-1:0]         i_wr_addr,
   input  logic [PIX_W-1:0]          i_wr_data,
   input  logic [ROW_W-1:0]          i_row,
   input  logic [COL_W-1:0]          i_col,
   input  logic [ADDR_W-1:0]         i_base,
   output logic [NUM_TAPS*PIX_W-1:0] o_win
);

   localparam int DEPTH = 3*IMG_W;

   logic [PIX_W-1:0]  r_mem [DEPTH];
   logic              w_up_ok;
   logic              w_dn_ok;
   logic              w_lf_ok;
   logic              w_rt_ok;
   logic [ADDR_W-1:0] w_rbase [3];
   logic [COL_W-1:0]  w_cidx  [3];
`ifndef MFE_WIN_REPLICATE_EN
   logic              w_rok   [3];
   logic              w_cok   [3];
`endif

   // Pixel store write; contents need no reset
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   // Row base addresses and column indices of the three rows/columns around
   // the centre. Row bases are multiples of IMG_W, so base+col never wraps.
   always_comb begin
      w_up_ok    = (i_row != '0);
      w_dn_ok    = (i_row != ROW_W'(IMG_H-1));
      w_lf_ok    = (i_col != '0);
      w_rt_ok    = (i_col != COL_W'(IMG_W-1));
      w_rbase[1] = i_base;
      w_rbase[0] = (i_base >= ADDR_W'(IMG_W))   ? i_base - ADDR_W'(IMG_W)
                                                : i_base + ADDR_W'(2*IMG_W);
      w_rbase[2] = (i_base >= ADDR_W'(2*IMG_W)) ? i_base - ADDR_W'(2*IMG_W)
                                                : i_base + ADDR_W'(IMG_W);
      w_cidx[0]  = i_col - COL_W'(1);
      w_cidx[1]  = i_col;
      w_cidx[2]  = i_col + COL_W'(1);
`ifdef MFE_WIN_REPLICATE_EN
      // Clamp out-of-image neighbours onto the centre row/column
      if (!w_up_ok) w_rbase[0] = i_base;
      if (!w_dn_ok) w_rbase[2] = i_base;
      if (!w_lf_ok) w_cidx[0]  = i_col;
      if (!w_rt_ok) w_cidx[2]  = i_col;
`else
      w_rok[0]   = w_up_ok;
      w_rok[1]   = 1'b1;
      w_rok[2]   = w_dn_ok;
      w_cok[0]   = w_lf_ok;
      w_cok[1]   = 1'b1;
      w_cok[2]   = w_rt_ok;
`endif
   end

   for (genvar gr = 0; gr < 3; gr++) begin : g_row
      for (genvar gc = 0; gc < 3; gc++) begin : g_col
         logic [ADDR_W-1:0] w_addr;
         assign w_addr = w_rbase[gr] + ADDR_W'(w_cidx[gc]);
`ifdef MFE_WIN_REPLICATE_EN
         assign o_win[(gr*3+gc)*PIX_W +: PIX_W] = r_mem[w_addr];
`else
         assign o_win[(gr*3+gc)*PIX_W +: PIX_W] =
            (w_rok[gr] && w_cok[gc]) ? r_mem[w_addr] : '0;
`endif
      end
   end

endmodule : mfe_line_store

`default_nettype wire

// File: rtl/mfe_window_gen.sv
// ============================================================================
// Module      : mfe_window_gen
// Description : Streaming 3x3 neighbourhood generator. Accepts one raster
//               frame on a valid/ready stream and emits one padded window per
//               pixel through a registered valid/ready output. Padding mode is
//               selected by MFE_WIN_REPLICATE_EN (zero padding when undefined).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mfe_window_gen
   import mfe_pkg::*;
#(
   parameter int IMG_W = DEF_IMG_W,
   parameter int IMG_H = DEF_IMG_H,
   parameter int PIX_W = DEF_PIX_W
)(
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   output logic                       busy,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [PIX_W-1:0]           in_pix,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [NUM_TAPS*PIX_W-1:0]  out_win,
   output logic [$clog2(IMG_H)-1:0]   out_row,
   output logic [$clog2(IMG_W)-1:0]   out_col,
   output logic                       frame_done
);

   localparam int TOTAL  = IMG_W*IMG_H;
   localparam int CNT_W  = $clog2(TOTAL + IMG_W + 3);
   localparam int DEPTH  = 3*IMG_W;
   localparam int ADDR_W = $clog2(DEPTH);
   localparam int ROW_W  = $clog2(IMG_H);
   localparam int COL_W  = $clog2(IMG_W);

   state_t                     r_state;
   state_t                     w_state_nxt;
   logic [CNT_W-1:0]           r_in_cnt;
   logic [CNT_W-1:0]           r_out_cnt;
   logic [CNT_W-1:0]           r_ld_cnt;
   logic [ROW_W-1:0]           r_ld_row;
   logic [COL_W-1:0]           r_ld_col;
   logic [ADDR_W-1:0]          r_ld_base;
   logic [ADDR_W-1:0]          r_wr_ptr;
   logic                       r_out_valid;
   logic [NUM_TAPS*PIX_W-1:0]  r_out_win;
   logic [ROW_W-1:0]           r_out_row;
   logic [COL_W-1:0]           r_out_col;
   logic [CNT_W-1:0]           w_lead;
   logic [CNT_W-1:0]           w_need;
   logic                       w_in_hs;
   logic                       w_out_hs;
   logic                       w_last_hs;
   logic                       w_load;
   logic [NUM_TAPS*PIX_W-1:0]  w_win;

   // Handshakes and the "next window can be loaded" decision. The window
   // being loaded (r_ld_cnt) needs all pixels up to one past its lower-right
   // neighbour, capped at the frame size.
   always_comb begin
      w_lead    = r_ld_cnt + CNT_W'(IMG_W+2);
      w_need    = (w_lead > CNT_W'(TOTAL)) ? CNT_W'(TOTAL) : w_lead;
      w_in_hs   = in_valid && in_ready;
      w_out_hs  = r_out_valid && out_ready;
      w_last_hs = w_out_hs && (r_out_cnt == CNT_W'(TOTAL-1));
      w_load    = (r_state != IDLE) && (r_ld_cnt < CNT_W'(TOTAL)) &&
                  (r_in_cnt >= w_need) && (!r_out_valid || w_out_hs);
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state: start only honoured in IDLE, frame ends on last handshake
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (start)                         w_state_nxt = RUN;
         RUN:     if (r_in_cnt == CNT_W'(TOTAL))     w_state_nxt = DRAIN;
         DRAIN:   if (w_last_hs)                     w_state_nxt = IDLE;
         default:                                    w_state_nxt = IDLE;
      endcase
   end

   // State outputs; the input lead bound keeps the 3-row store from
   // overwriting pixels still needed by the next window to be loaded
   always_comb begin
      busy       = (r_state != IDLE);
      in_ready   = (r_state == RUN) &&
                   (r_in_cnt < r_out_cnt + CNT_W'(IMG_W+2)) &&
                   (r_in_cnt < CNT_W'(TOTAL));
      frame_done = (r_state == DRAIN) && w_last_hs;
   end

   // Counters, write pointer, load position and the output window register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_in_cnt    <= '0;
         r_out_cnt   <= '0;
         r_ld_cnt    <= '0;
         r_ld_row    <= '0;
         r_ld_col    <= '0;
         r_ld_base   <= '0;
         r_wr_ptr    <= '0;
         r_out_valid <= 1'b0;
         r_out_win   <= '0;
         r_out_row   <= '0;
         r_out_col   <= '0;
      end else if (r_state == IDLE) begin
         if (start) begin
            r_in_cnt    <= '0;
            r_out_cnt   <= '0;
            r_ld_cnt    <= '0;
            r_ld_row    <= '0;
            r_ld_col    <= '0;
            r_ld_base   <= '0;
            r_wr_ptr    <= '0;
            r_out_valid <= 1'b0;
         end
      end else begin
         if (w_in_hs) begin
            r_in_cnt <= r_in_cnt + CNT_W'(1);
            r_wr_ptr <= (r_wr_ptr == ADDR_W'(DEPTH-1)) ? '0 : r_wr_ptr + ADDR_W'(1);
         end
         if (w_out_hs) begin
            r_out_cnt <= r_out_cnt + CNT_W'(1);
         end
         if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_win   <= w_win;
            r_out_row   <= r_ld_row;
            r_out_col   <= r_ld_col;
            r_ld_cnt    <= r_ld_cnt + CNT_W'(1);
            if (r_ld_col == COL_W'(IMG_W-1)) begin
               r_ld_col  <= '0;
               r_ld_row  <= r_ld_row + ROW_W'(1);
               r_ld_base <= (r_ld_base == ADDR_W'(2*IMG_W)) ? '0
                                                            : r_ld_base + ADDR_W'(IMG_W);
            end else begin
               r_ld_col  <= r_ld_col + COL_W'(1);
            end
         end else if (w_out_hs) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   mfe_line_store #(
      .IMG_W (IMG_W),
      .IMG_H (IMG_H),
      .PIX_W (PIX_W)
   ) u_store (
      .clk       (clk),
      .i_wr_en   (w_in_hs),
      .i_wr_addr (r_wr_ptr),
      .i_wr_data (in_pix),
      .i_row     (r_ld_row),
      .i_col     (r_ld_col),
      .i_base    (r_ld_base),
      .o_win     (w_win)
   );

   assign out_valid = r_out_valid;
   assign out_win   = r_out_win;
   assign out_row   = r_out_row;
   assign out_col   = r_out_col;

endmodule : mfe_window_gen

`default_nettype wire
